// File: rtl/hsv_core_ctrlstatus_csr_initiator.sv
// Purpose: CSR bus initiator; privilege/read-only checks, then read and/or masked write to the register block.
// Latency: accept->out_valid 3 cycles (read+write), 2 (single phase), 1 (illegal), +1 per stall/ack-wait cycle.
// Backpressure: in_ready only in IDLE; cpuif_req_stall holds the request; RESP holds out_* until out_ready.
module hsv_core_ctrlstatus_csr_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [11:0] in_addr,
    input  logic [31:0] in_operand,
    input  logic        in_rd_zero,
    input  logic        in_rs_zero,
    input  logic [1:0]  priv_i,
    output logic        cpuif_req,
    output logic        cpuif_req_is_wr,
    output logic [13:0] cpuif_addr,
    output logic [31:0] cpuif_wr_data,
    output logic [31:0] cpuif_wr_biten,
    input  logic        cpuif_req_stall,
    input  logic        cpuif_rd_ack,
    input  logic        cpuif_rd_err,
    input  logic [31:0] cpuif_rd_data,
    input  logic        cpuif_wr_ack,
    input  logic        cpuif_wr_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_exception
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_RW    = 2'b01;
    localparam logic [1:0] OP_RC    = 2'b11;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        need_wr_q;
    logic [7:0]  tmo_cnt;

    logic        acc_need_rd;
    logic        acc_need_wr;
    logic        acc_illegal;
    logic [31:0] acc_wr_data;
    logic [31:0] acc_wr_biten;

    logic        phase_is_wr;
    logic        phase_in_req;
    logic        phase_ack;
    logic        phase_err;
    logic        tmo_hit;

    assign in_ready = (state == S_IDLE);

    // Decode of the offered request; only consumed in the accept cycle, so it never reaches cpuif_* combinationally.
    always_comb begin
        acc_need_rd  = !((in_op == OP_RW) && in_rd_zero);
        acc_need_wr  = (in_op == OP_RW) || !in_rs_zero;
        acc_illegal  = (in_addr[9:8] > priv_i) || (acc_need_wr && (in_addr[11:10] == 2'b11));
        // Set/clear rely on the responder applying wr_data only where biten is 1.
        acc_wr_data  = 32'hFFFF_FFFF;
        acc_wr_biten = in_operand;
        case (in_op)
            OP_RW: begin
                acc_wr_data  = in_operand;
                acc_wr_biten = 32'hFFFF_FFFF;
            end
            OP_RC: begin
                acc_wr_data  = 32'h0000_0000;
                acc_wr_biten = in_operand;
            end
            default: ;
        endcase
    end

    // Bus phase qualifiers: an ack only counts once the request has actually been taken.
    always_comb begin
        phase_is_wr  = (state == S_WR_REQ) || (state == S_WR_WAIT);
        phase_in_req = (state == S_RD_REQ) || (state == S_WR_REQ);
        phase_ack    = (phase_is_wr ? cpuif_wr_ack : cpuif_rd_ack) && !(phase_in_req && cpuif_req_stall);
        phase_err    = phase_is_wr ? cpuif_wr_err : cpuif_rd_err;
        tmo_hit      = (tmo_cnt == TMO_LAST);
    end

    // Transaction FSM with all bus and result outputs registered.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state           <= S_IDLE;
            need_wr_q       <= 1'b0;
            tmo_cnt         <= 8'd0;
            cpuif_req       <= 1'b0;
            cpuif_req_is_wr <= 1'b0;
            cpuif_addr      <= 14'd0;
            cpuif_wr_data   <= 32'd0;
            cpuif_wr_biten  <= 32'd0;
            out_valid       <= 1'b0;
            out_rdata       <= 32'd0;
            out_exception   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        need_wr_q      <= acc_need_wr;
                        tmo_cnt        <= 8'd0;
                        cpuif_addr     <= {in_addr, 2'b00};
                        cpuif_wr_data  <= acc_wr_data;
                        cpuif_wr_biten <= acc_wr_biten;
                        out_rdata      <= 32'd0;
                        out_exception  <= 1'b0;
                        if (acc_illegal) begin
                            out_exception <= 1'b1;
                            out_valid     <= 1'b1;
                            state         <= S_RESP;
                        end else if (acc_need_rd) begin
                            cpuif_req       <= 1'b1;
                            cpuif_req_is_wr <= 1'b0;
                            state           <= S_RD_REQ;
                        end else begin
                            cpuif_req       <= 1'b1;
                            cpuif_req_is_wr <= 1'b1;
                            state           <= S_WR_REQ;
                        end
                    end
                end
                S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT: begin
                    if (phase_ack) begin
                        cpuif_req <= 1'b0;
                        if (!phase_is_wr) begin
                            out_rdata <= cpuif_rd_data;
                        end
                        if (phase_err) begin
                            out_exception <= 1'b1;
                            out_valid     <= 1'b1;
                            state         <= S_RESP;
                        end else if (!phase_is_wr && need_wr_q) begin
                            cpuif_req       <= 1'b1;
                            cpuif_req_is_wr <= 1'b1;
                            tmo_cnt         <= 8'd0;
                            state           <= S_WR_REQ;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the phase; a pending write is deliberately not retried.
                        cpuif_req     <= 1'b0;
                        out_exception <= 1'b1;
                        out_valid     <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (phase_in_req && !cpuif_req_stall) begin
                            cpuif_req <= 1'b0;
                            if (phase_is_wr) begin
                                state <= S_WR_WAIT;
                            end else begin
                                state <= S_RD_WAIT;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_csr_initiator.sv
// Purpose: self-checking bench for the CSR bus initiator with a scripted register-block responder.
// Latency: checks accept->out_valid cycle counts against hand-computed values.
// Backpressure: responder scripts stall/ack-wait cycles; out_ready is held low in one case.
`timescale 1ns/1ps
module tb_hsv_core_ctrlstatus_csr_initiator;

    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;
    always #5 clk_core = ~clk_core;

    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [11:0] in_addr;
    logic [31:0] in_operand;
    logic        in_rd_zero, in_rs_zero;
    logic [1:0]  priv_i;
    logic        cpuif_req, cpuif_req_is_wr;
    logic [13:0] cpuif_addr;
    logic [31:0] cpuif_wr_data, cpuif_wr_biten;
    logic        cpuif_req_stall, cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
    logic [31:0] cpuif_rd_data;
    logic        out_valid, out_ready, out_exception;
    logic [31:0] out_rdata;

    // Second instance with a short timeout, driven directly.
    logic        t_in_valid, t_in_ready, t_req, t_req_is_wr, t_stall, t_rd_ack;
    logic [13:0] t_addr;
    logic [31:0] t_wr_data, t_wr_biten, t_rd_data, t_out_rdata;
    logic        t_out_valid, t_out_ready, t_out_exception;

    hsv_core_ctrlstatus_csr_initiator dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_operand(in_operand), .in_rd_zero(in_rd_zero), .in_rs_zero(in_rs_zero), .priv_i(priv_i),
        .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
        .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten), .cpuif_req_stall(cpuif_req_stall),
        .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
        .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_exception(out_exception)
    );

    hsv_core_ctrlstatus_csr_initiator #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk_core(clk_core), .rst_core_n(rst_core_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_operand(in_operand), .in_rd_zero(in_rd_zero), .in_rs_zero(in_rs_zero), .priv_i(priv_i),
        .cpuif_req(t_req), .cpuif_req_is_wr(t_req_is_wr), .cpuif_addr(t_addr),
        .cpuif_wr_data(t_wr_data), .cpuif_wr_biten(t_wr_biten), .cpuif_req_stall(t_stall),
        .cpuif_rd_ack(t_rd_ack), .cpuif_rd_err(1'b0), .cpuif_rd_data(t_rd_data),
        .cpuif_wr_ack(1'b0), .cpuif_wr_err(1'b0),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_rdata(t_out_rdata), .out_exception(t_out_exception)
    );

    typedef struct { logic [31:0] rdata; logic exc; int lat; int acc; } resp_t;
    typedef struct { logic is_wr; logic [13:0] addr; logic [31:0] data; logic [31:0] biten; } bus_t;

    resp_t sb_q[$];
    bus_t  bus_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Responder script for the next bus phase(s).
    int          cfg_stall = 0, cfg_wait = 0;
    logic [31:0] cfg_rd_data = '0;
    logic        cfg_rd_err = 1'b0, cfg_wr_err = 1'b0, cfg_silent = 1'b0;

    always @(posedge clk_core) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h, nothing expected (t=%0t)", name, act, $time);
    endtask

    // Responder plus bus monitor: decides stall/ack for the current cycle and checks the presented request.
    int   r_stall = 0, r_wait = 0;
    logic r_active = 1'b0;
    logic cur_ok = 1'b0;
    bus_t cur_bus;
    always @(negedge clk_core) begin
        cpuif_req_stall = 1'b0;
        cpuif_rd_ack    = 1'b0;
        cpuif_rd_err    = 1'b0;
        cpuif_rd_data   = 32'd0;
        cpuif_wr_ack    = 1'b0;
        cpuif_wr_err    = 1'b0;
        if (!rst_core_n) begin
            r_active = 1'b0;
        end else begin
            if (cpuif_req && !r_active) begin
                r_active = 1'b1;
                r_stall  = cfg_stall;
                r_wait   = cfg_wait;
                if (bus_q.size() == 0) begin
                    flag("unexpected_bus_req", 32'(cpuif_addr));
                    cur_ok = 1'b0;
                end else begin
                    cur_bus = bus_q.pop_front();
                    cur_ok  = 1'b1;
                end
            end
            if (cpuif_req && cur_ok) begin
                check("bus_is_wr", 32'(cpuif_req_is_wr), 32'(cur_bus.is_wr));
                check("bus_addr", 32'(cpuif_addr), 32'(cur_bus.addr));
                if (cur_bus.is_wr) begin
                    check("bus_wr_data", cpuif_wr_data, cur_bus.data);
                    check("bus_wr_biten", cpuif_wr_biten, cur_bus.biten);
                end
            end
            if (r_active) begin
                if (cpuif_req && r_stall > 0) begin
                    cpuif_req_stall = 1'b1;
                    r_stall--;
                end else if (r_wait > 0) begin
                    r_wait--;
                end else if (!cfg_silent) begin
                    if (cpuif_req_is_wr) begin
                        cpuif_wr_ack = 1'b1;
                        cpuif_wr_err = cfg_wr_err;
                    end else begin
                        cpuif_rd_ack  = 1'b1;
                        cpuif_rd_data = cfg_rd_data;
                        cpuif_rd_err  = cfg_rd_err;
                    end
                    r_active = 1'b0;
                end
            end
        end
    end

    // Result monitor: pops the expected response when out_valid first rises, re-checks while held.
    logic  resp_open = 1'b0;
    resp_t cur;
    always @(negedge clk_core) begin
        if (rst_core_n && out_valid) begin
            if (!resp_open) begin
                resp_open = 1'b1;
                if (sb_q.size() == 0) begin
                    flag("unexpected_resp", out_rdata);
                    cur = '{out_rdata, out_exception, 0, 0};
                end else begin
                    cur = sb_q.pop_front();
                    check("resp_rdata", out_rdata, cur.rdata);
                    check("resp_exception", 32'(out_exception), 32'(cur.exc));
                    check("resp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end else begin
                check("resp_hold_rdata", out_rdata, cur.rdata);
                check("resp_hold_exception", 32'(out_exception), 32'(cur.exc));
            end
            if (out_ready) resp_open = 1'b0;
        end
    end

    task automatic set_resp(input int st, input int wt, input logic [31:0] rd, input logic rerr,
                            input logic werr, input logic silent);
        cfg_stall = st; cfg_wait = wt; cfg_rd_data = rd;
        cfg_rd_err = rerr; cfg_wr_err = werr; cfg_silent = silent;
    endtask

    task automatic exp_bus(input logic is_wr, input logic [13:0] addr, input logic [31:0] data,
                           input logic [31:0] biten);
        bus_q.push_back('{is_wr, addr, data, biten});
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_core);
        while (!in_ready && n < 200) begin
            @(negedge clk_core);
            n++;
        end
        if (!in_ready) flag("idle_timeout", 32'(n));
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] opnd,
                         input logic rdz, input logic rsz, input logic [1:0] priv, input logic push,
                         input logic [31:0] exp_rd, input logic exp_exc, input int exp_lat);
        wait_idle();
        in_op = op; in_addr = addr; in_operand = opnd;
        in_rd_zero = rdz; in_rs_zero = rsz; priv_i = priv;
        in_valid = 1'b1;
        if (push) sb_q.push_back('{exp_rd, exp_exc, exp_lat, cyc});
        @(negedge clk_core);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_op = 2'b01; in_addr = '0; in_operand = '0;
        in_rd_zero = 1'b0; in_rs_zero = 1'b0; priv_i = 2'd3; out_ready = 1'b1;
        t_in_valid = 1'b0; t_stall = 1'b0; t_rd_ack = 1'b0; t_rd_data = '0; t_out_ready = 1'b0;

        // Reset values
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req", 32'(cpuif_req), 32'd0);
        check("rst_is_wr", 32'(cpuif_req_is_wr), 32'd0);
        check("rst_addr", 32'(cpuif_addr), 32'd0);
        check("rst_wr_data", cpuif_wr_data, 32'd0);
        check("rst_biten", cpuif_wr_biten, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rdata", out_rdata, 32'd0);
        check("rst_exception", 32'(out_exception), 32'd0);
        check("rst_t_in_ready", 32'(t_in_ready), 32'd1);
        @(posedge clk_core); @(posedge clk_core); #1;
        rst_core_n = 1'b1;

        // CSRRS 0xB00 |= 0xF0, zero-cycle acks
        wait_idle(); set_resp(0, 0, 32'h1234_5600, 1'b0, 1'b0, 1'b0);
        exp_bus(1'b0, 14'h2C00, 32'h0, 32'h0);
        exp_bus(1'b1, 14'h2C00, 32'hFFFF_FFFF, 32'h0000_00F0);
        issue(2'b10, 12'hB00, 32'h0000_00F0, 1'b0, 1'b0, 2'd3, 1'b1, 32'h1234_5600, 1'b0, 3);

        // CSRRW to x0: write only
        wait_idle(); set_resp(0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        exp_bus(1'b1, 14'h2C08, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        issue(2'b01, 12'hB02, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd3, 1'b1, 32'h0, 1'b0, 2);

        // CSRRS with rs=0 on a read-only user CSR: read only, legal
        wait_idle(); set_resp(0, 0, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
        exp_bus(1'b0, 14'h3000, 32'h0, 32'h0);
        issue(2'b10, 12'hC00, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0000_1111, 1'b0, 2);

        // Same CSR with a nonzero set mask: write to read-only -> illegal, no bus
        wait_idle();
        issue(2'b10, 12'hC00, 32'h0000_0005, 1'b0, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 1);

        // Machine CSR from user mode -> illegal
        wait_idle();
        issue(2'b10, 12'h300, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 1'b1, 1);

        // Machine CSR from supervisor mode -> illegal
        wait_idle();
        issue(2'b10, 12'h300, 32'h0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0, 1'b1, 1);

        // CSRRW to x0 on read-only CSR -> illegal
        wait_idle();
        issue(2'b01, 12'hC01, 32'h1, 1'b1, 1'b0, 2'd3, 1'b1, 32'h0, 1'b1, 1);

        // Read-only with 3 stall cycles then 2 ack-wait cycles: 2 + 5
        wait_idle(); set_resp(3, 2, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
        exp_bus(1'b0, 14'h2C00, 32'h0, 32'h0);
        issue(2'b10, 12'hB00, 32'h0, 1'b0, 1'b1, 2'd3, 1'b1, 32'hCAFE_0001, 1'b0, 7);

        // CSRRC 0x340 with out_ready held low for two extra cycles
        wait_idle(); set_resp(0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        exp_bus(1'b0, 14'h0D00, 32'h0, 32'h0);
        exp_bus(1'b1, 14'h0D00, 32'h0000_0000, 32'h0000_0F0F);
        issue(2'b11, 12'h340, 32'h0000_0F0F, 1'b0, 1'b0, 2'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 3);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk_core);
        repeat (2) @(negedge clk_core);
        @(posedge clk_core); #1;
        out_ready = 1'b1;

        // CSRRW with read, one ack-wait cycle per phase: 3 + 2
        wait_idle(); set_resp(0, 1, 32'h0000_1800, 1'b0, 1'b0, 1'b0);
        exp_bus(1'b0, 14'h0C14, 32'h0, 32'h0);
        exp_bus(1'b1, 14'h0C14, 32'h8000_0001, 32'hFFFF_FFFF);
        issue(2'b01, 12'h305, 32'h8000_0001, 1'b0, 1'b0, 2'd3, 1'b1, 32'h0000_1800, 1'b0, 5);

        // Write-phase error keeps the read data
        wait_idle(); set_resp(0, 0, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0);
        exp_bus(1'b0, 14'h0400, 32'h0, 32'h0);
        exp_bus(1'b1, 14'h0400, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(2'b10, 12'h100, 32'h0000_0002, 1'b0, 1'b0, 2'd1, 1'b1, 32'hA5A5_0000, 1'b1, 3);

        // Reset pulse while waiting for a read ack: no response, outputs at reset values
        wait_idle(); set_resp(0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        exp_bus(1'b0, 14'h2C00, 32'h0, 32'h0);
        issue(2'b10, 12'hB00, 32'h0000_0001, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk_core);
        #2 rst_core_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_req", 32'(cpuif_req), 32'd0);
        check("mid_rst_is_wr", 32'(cpuif_req_is_wr), 32'd0);
        check("mid_rst_addr", 32'(cpuif_addr), 32'd0);
        check("mid_rst_wr_data", cpuif_wr_data, 32'd0);
        check("mid_rst_biten", cpuif_wr_biten, 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rdata", out_rdata, 32'd0);
        check("mid_rst_exception", 32'(out_exception), 32'd0);
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        set_resp(0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk_core);

        // Timeout of 4 on a stalled read, then late acks in RESP and IDLE
        @(negedge clk_core);
        in_op = 2'b10; in_addr = 12'hB00; in_operand = 32'h0000_0001;
        in_rd_zero = 1'b0; in_rs_zero = 1'b0; priv_i = 2'd3;
        t_stall = 1'b1; t_in_valid = 1'b1;
        @(negedge clk_core);
        t_in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("tmo_req_held", 32'(t_req), 32'd1);
            check("tmo_is_wr", 32'(t_req_is_wr), 32'd0);
            check("tmo_addr", 32'(t_addr), 32'h0000_2C00);
            check("tmo_wr_data", t_wr_data, 32'hFFFF_FFFF);
            check("tmo_biten", t_wr_biten, 32'h0000_0001);
            check("tmo_no_valid", 32'(t_out_valid), 32'd0);
            @(negedge clk_core);
        end
        check("tmo_req_dropped", 32'(t_req), 32'd0);
        check("tmo_valid", 32'(t_out_valid), 32'd1);
        check("tmo_exception", 32'(t_out_exception), 32'd1);
        check("tmo_rdata", t_out_rdata, 32'd0);
        t_stall = 1'b0; t_rd_ack = 1'b1; t_rd_data = 32'hFFFF_FFFF;
        @(negedge clk_core);
        check("late_ack_resp_valid", 32'(t_out_valid), 32'd1);
        check("late_ack_resp_rdata", t_out_rdata, 32'd0);
        check("late_ack_resp_exc", 32'(t_out_exception), 32'd1);
        check("late_ack_resp_req", 32'(t_req), 32'd0);
        t_out_ready = 1'b1;
        @(negedge clk_core);
        t_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("late_ack_idle_in_ready", 32'(t_in_ready), 32'd1);
            check("late_ack_idle_valid", 32'(t_out_valid), 32'd0);
            check("late_ack_idle_req", 32'(t_req), 32'd0);
            check("late_ack_idle_rdata", t_out_rdata, 32'd0);
            @(negedge clk_core);
        end
        t_rd_ack = 1'b0;

        wait_idle();
        repeat (2) @(negedge clk_core);
        check("sb_queue_drained", 32'(sb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
